// File: rtl/output_argmax.sv
// Sequential argmax over a signed logit vector with valid/yumi handshakes on both sides.
// Optional runner-up margin output is enabled by defining ARGMAX_MARGIN_EN.
module output_argmax #(
    parameter int WORD_SIZE   = 16,
    parameter int N_SIZE      = 12,
    parameter int OUTPUT_SIZE = 10,
    parameter int INDEX_BITS  = $clog2(OUTPUT_SIZE)
) (
    input  logic                                  clk_i,
    input  logic                                  reset_n_i,
    input  logic                                  valid_i,
    input  logic [OUTPUT_SIZE-1:0][WORD_SIZE-1:0] data_i,
    output logic                                  yumi_o,
    output logic                                  valid_o,
    output logic [INDEX_BITS-1:0]                 class_o,
    output logic [WORD_SIZE-1:0]                  max_o,
`ifdef ARGMAX_MARGIN_EN
    output logic [WORD_SIZE-1:0]                  margin_o,
`endif
    input  logic                                  yumi_i
);

    if (OUTPUT_SIZE < 2 || N_SIZE >= WORD_SIZE) begin : g_param_check
        $error("output_argmax: OUTPUT_SIZE must be >= 2 and N_SIZE < WORD_SIZE");
    end

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] SCAN = 2'd1;
    localparam logic [1:0] DONE = 2'd2;
    localparam logic [INDEX_BITS-1:0] LAST_IDX = INDEX_BITS'(OUTPUT_SIZE - 1);

    logic [1:0]                            state_r;
    logic [OUTPUT_SIZE-1:0][WORD_SIZE-1:0] vec_r;
    logic [INDEX_BITS-1:0]                 cnt_r;
    logic signed [WORD_SIZE-1:0]           run_max_r;
    logic [INDEX_BITS-1:0]                 run_idx_r;
    logic signed [WORD_SIZE-1:0]           elem_s;
    logic signed [WORD_SIZE-1:0]           nxt_max_s;
    logic [INDEX_BITS-1:0]                 nxt_idx_s;
    logic                                  take_s;
    logic                                  last_s;

`ifdef ARGMAX_MARGIN_EN
    logic signed [WORD_SIZE-1:0] run_sec_r;
    logic signed [WORD_SIZE-1:0] nxt_sec_s;

    // Difference of two signed words is non-negative here; clamp anything past the unsigned range.
    function automatic logic [WORD_SIZE-1:0] sat_margin(input logic [WORD_SIZE-1:0] hi,
                                                        input logic [WORD_SIZE-1:0] lo);
        logic [WORD_SIZE:0] diff;
        diff = {hi[WORD_SIZE-1], hi} - {lo[WORD_SIZE-1], lo};
        if (diff[WORD_SIZE]) begin
            return {WORD_SIZE{1'b1}};
        end else begin
            return diff[WORD_SIZE-1:0];
        end
    endfunction
`endif

    assign yumi_o = (state_r == IDLE) & valid_i & reset_n_i;

    // Compare the current element against the running winner; ties keep the lower index.
    always_comb begin
        elem_s = vec_r[cnt_r];
        take_s = elem_s > run_max_r;
        last_s = (cnt_r == LAST_IDX);
        if (take_s) begin
            nxt_max_s = elem_s;
            nxt_idx_s = cnt_r;
        end else begin
            nxt_max_s = run_max_r;
            nxt_idx_s = run_idx_r;
        end
`ifdef ARGMAX_MARGIN_EN
        if (take_s) begin
            nxt_sec_s = run_max_r;
        end else if (elem_s > run_sec_r) begin
            nxt_sec_s = elem_s;
        end else begin
            nxt_sec_s = run_sec_r;
        end
`endif
    end

    // Handshake FSM, scan datapath and registered result.
    always_ff @(posedge clk_i) begin
        if (!reset_n_i) begin
            state_r   <= IDLE;
            vec_r     <= '0;
            cnt_r     <= '0;
            run_max_r <= '0;
            run_idx_r <= '0;
            valid_o   <= 1'b0;
            class_o   <= '0;
            max_o     <= '0;
`ifdef ARGMAX_MARGIN_EN
            run_sec_r <= '0;
            margin_o  <= '0;
`endif
        end else begin
            case (state_r)
                IDLE: begin
                    if (valid_i) begin
                        vec_r     <= data_i;
                        run_max_r <= data_i[0];
                        run_idx_r <= '0;
                        cnt_r     <= INDEX_BITS'(1);
`ifdef ARGMAX_MARGIN_EN
                        // Most negative value so any real element becomes the runner-up.
                        run_sec_r <= {1'b1, {(WORD_SIZE-1){1'b0}}};
`endif
                        state_r   <= SCAN;
                    end
                end
                SCAN: begin
                    run_max_r <= nxt_max_s;
                    run_idx_r <= nxt_idx_s;
                    cnt_r     <= cnt_r + INDEX_BITS'(1);
`ifdef ARGMAX_MARGIN_EN
                    run_sec_r <= nxt_sec_s;
`endif
                    if (last_s) begin
                        class_o <= nxt_idx_s;
                        max_o   <= nxt_max_s;
`ifdef ARGMAX_MARGIN_EN
                        margin_o <= sat_margin(nxt_max_s, nxt_sec_s);
`endif
                        valid_o <= 1'b1;
                        state_r <= DONE;
                    end
                end
                DONE: begin
                    if (yumi_i) begin
                        valid_o <= 1'b0;
                        state_r <= IDLE;
                    end
                end
                default: begin
                    valid_o <= 1'b0;
                    state_r <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_output_argmax.sv
// Self-checking bench for output_argmax: directed and random vectors against a loop-based argmax model.
module tb_output_argmax;

    localparam int W  = 16;
    localparam int N  = 10;
    localparam int IB = $clog2(N);

    typedef logic [N-1:0][W-1:0] vec_t;

    logic          clk_i = 1'b0;
    logic          reset_n_i;
    logic          valid_i;
    vec_t          data_i;
    logic          yumi_o;
    logic          valid_o;
    logic [IB-1:0] class_o;
    logic [W-1:0]  max_o;
    logic          yumi_i;
`ifdef ARGMAX_MARGIN_EN
    logic [W-1:0]  margin_o;
`endif

    int checks   = 0;
    int failures = 0;

    output_argmax dut (
        .clk_i     (clk_i),
        .reset_n_i (reset_n_i),
        .valid_i   (valid_i),
        .data_i    (data_i),
        .yumi_o    (yumi_o),
        .valid_o   (valid_o),
        .class_o   (class_o),
        .max_o     (max_o),
`ifdef ARGMAX_MARGIN_EN
        .margin_o  (margin_o),
`endif
        .yumi_i    (yumi_i)
    );

    always #5 clk_i = ~clk_i;

    // Argmax by exhaustive search: first index holding the largest signed value; margin to best other element.
    function automatic void ref_model(input vec_t v, output int cls, output logic [W-1:0] mx,
                                      output logic [W-1:0] mg);
        int best, ru, val, diff;
        best = -100000;
        cls  = 0;
        for (int k = 0; k < N; k++) begin
            val = $signed(v[k]);
            if (val > best) begin
                best = val;
                cls  = k;
            end
        end
        ru = -100000;
        for (int k = 0; k < N; k++) begin
            val = $signed(v[k]);
            if (k != cls && val > ru) ru = val;
        end
        diff = best - ru;
        if (diff > 65535) diff = 65535;
        mx = W'(best);
        mg = W'(diff);
    endfunction

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    // Present a vector until yumi_o; returns at the cycle after acceptance.
    task automatic offer(input vec_t v, output bit ok);
        ok = 1'b0;
        data_i  = v;
        valid_i = 1'b1;
        for (int i = 0; i < 60; i++) begin
            #1;
            if (yumi_o === 1'b1) begin
                ok = 1'b1;
                break;
            end
            step();
        end
        step();
        valid_i = 1'b0;
    endtask

    // Counts cycles from acceptance until valid_o, starting at the cycle after acceptance.
    task automatic wait_valid(output int lat, output bit ok);
        ok  = 1'b0;
        lat = 0;
        for (int n = 1; n <= 60; n++) begin
            if (valid_o === 1'b1) begin
                ok  = 1'b1;
                lat = n;
                break;
            end
            step();
        end
    endtask

    task automatic test_reset();
        reset_n_i = 1'b0;
        valid_i   = 1'b1;
        yumi_i    = 1'b0;
        data_i    = '1;
        for (int i = 0; i < 2; i++) begin
            step();
            checks++;
            if (yumi_o !== 1'b0 || valid_o !== 1'b0 || class_o !== IB'(0) || max_o !== 16'h0000) begin
                failures++;
                $display("FAIL reset: yumi_o=%b valid_o=%b class_o=%0d max_o=%h required 0/0/0/0000",
                         yumi_o, valid_o, class_o, max_o);
            end
        end
        valid_i   = 1'b0;
        reset_n_i = 1'b1;
        step();
    endtask

    task automatic test_argmax_vector(input string name, input vec_t v);
        bit ok;
        int lat, cls;
        logic [W-1:0] mx, mg;
        ref_model(v, cls, mx, mg);
        offer(v, ok);
        checks++;
        if (!ok) begin
            failures++;
            $display("FAIL %s accept: yumi_o never rose", name);
        end
        wait_valid(lat, ok);
        checks++;
        if (!ok || lat != N) begin
            failures++;
            $display("FAIL %s latency: got %0d (ok=%0d) required %0d", name, lat, ok, N);
        end
        checks++;
        if (class_o !== IB'(cls) || max_o !== mx) begin
            failures++;
            $display("FAIL %s result: class_o=%0d max_o=%h required %0d %h", name, class_o, max_o, cls, mx);
        end
`ifdef ARGMAX_MARGIN_EN
        checks++;
        if (margin_o !== mg) begin
            failures++;
            $display("FAIL %s margin: margin_o=%h required %h", name, margin_o, mg);
        end
`endif
        yumi_i = 1'b1;
        step();
        yumi_i = 1'b0;
        checks++;
        if (valid_o !== 1'b0 || class_o !== IB'(cls) || max_o !== mx) begin
            failures++;
            $display("FAIL %s release: valid_o=%b class_o=%0d max_o=%h required 0 %0d %h",
                     name, valid_o, class_o, max_o, cls, mx);
        end
    endtask

    task automatic test_basic();
        vec_t v;
        v = '0;
        v[7] = 16'h1800;
        v[3] = 16'h1000;
        test_argmax_vector("basic", v);
        checks++;
        if (class_o !== IB'(7) || max_o !== 16'h1800) begin
            failures++;
            $display("FAIL basic_const: class_o=%0d max_o=%h required 7 1800", class_o, max_o);
        end
    endtask

    task automatic test_signed_tie();
        vec_t v;
        for (int k = 0; k < N; k++) v[k] = 16'hF000;
        v[2] = 16'hFF00;
        v[5] = 16'hFF00;
        test_argmax_vector("signed_tie", v);
        checks++;
        if (class_o !== IB'(2) || max_o !== 16'hFF00) begin
            failures++;
            $display("FAIL tie_const: class_o=%0d max_o=%h required 2 ff00", class_o, max_o);
        end
    endtask

    task automatic test_extremes();
        vec_t v;
        for (int k = 0; k < N; k++) v[k] = 16'h8000;
        v[9] = 16'h7FFF;
        test_argmax_vector("extremes", v);
        for (int k = 0; k < N; k++) v[k] = 16'h8000;
        test_argmax_vector("all_min", v);
    endtask

    task automatic test_random();
        vec_t v;
        for (int t = 0; t < 25; t++) begin
            for (int k = 0; k < N; k++) begin
                case (t % 3)
                    0:       v[k] = W'($urandom);
                    1:       v[k] = W'($urandom_range(0, 3)) << 12;
                    default: v[k] = ($urandom_range(0, 1) == 0) ? 16'h8000 : W'($urandom_range(0, 65535));
                endcase
            end
            test_argmax_vector("random", v);
        end
    endtask

    task automatic test_back_to_back();
        vec_t a, b;
        bit ok;
        int lat, cls_a, cls_b;
        logic [W-1:0] mx_a, mg_a, mx_b, mg_b;
        for (int k = 0; k < N; k++) begin
            a[k] = W'($urandom);
            b[k] = W'($urandom);
        end
        ref_model(a, cls_a, mx_a, mg_a);
        ref_model(b, cls_b, mx_b, mg_b);
        offer(a, ok);
        wait_valid(lat, ok);
        checks++;
        if (!ok || lat != N) begin
            failures++;
            $display("FAIL b2b_first: latency %0d ok=%0d required %0d", lat, ok, N);
        end
        data_i  = b;
        valid_i = 1'b1;
        for (int i = 0; i < 20; i++) begin
            #1;
            checks++;
            if (valid_o !== 1'b1 || yumi_o !== 1'b0 || class_o !== IB'(cls_a) || max_o !== mx_a) begin
                failures++;
                $display("FAIL b2b_hold cycle %0d: valid_o=%b yumi_o=%b class_o=%0d max_o=%h required 1 0 %0d %h",
                         i, valid_o, yumi_o, class_o, max_o, cls_a, mx_a);
            end
            step();
        end
        yumi_i = 1'b1;
        #1;
        checks++;
        if (yumi_o !== 1'b0) begin
            failures++;
            $display("FAIL b2b_no_bypass: yumi_o=%b required 0", yumi_o);
        end
        step();
        yumi_i = 1'b0;
        #1;
        checks++;
        if (valid_o !== 1'b0 || yumi_o !== 1'b1 || class_o !== IB'(cls_a)) begin
            failures++;
            $display("FAIL b2b_reaccept: valid_o=%b yumi_o=%b class_o=%0d required 0 1 %0d",
                     valid_o, yumi_o, class_o, cls_a);
        end
        step();
        valid_i = 1'b0;
        wait_valid(lat, ok);
        checks++;
        if (!ok || lat != N || class_o !== IB'(cls_b) || max_o !== mx_b) begin
            failures++;
            $display("FAIL b2b_second: lat=%0d class_o=%0d max_o=%h required %0d %0d %h",
                     lat, class_o, max_o, N, cls_b, mx_b);
        end
        yumi_i = 1'b1;
        step();
        yumi_i = 1'b0;
    endtask

    task automatic test_reset_mid_scan();
        vec_t v;
        bit ok, seen;
        for (int k = 0; k < N; k++) v[k] = W'($urandom);
        offer(v, ok);
        step();
        step();
        step();
        reset_n_i = 1'b0;
        step();
        reset_n_i = 1'b1;
        checks++;
        if (valid_o !== 1'b0 || class_o !== IB'(0) || max_o !== 16'h0000) begin
            failures++;
            $display("FAIL midscan_reset: valid_o=%b class_o=%0d max_o=%h required 0 0 0000",
                     valid_o, class_o, max_o);
        end
        seen = 1'b0;
        for (int i = 0; i < 15; i++) begin
            if (valid_o !== 1'b0) seen = 1'b1;
            step();
        end
        checks++;
        if (seen) begin
            failures++;
            $display("FAIL midscan_discard: valid_o=1 seen required 0");
        end
        v = '0;
        v[4] = 16'h0123;
        test_argmax_vector("after_reset", v);
    endtask

    initial begin
        reset_n_i = 1'b0;
        valid_i   = 1'b0;
        yumi_i    = 1'b0;
        data_i    = '0;
        test_reset();
        test_basic();
        test_signed_tie();
        test_extremes();
        test_random();
        test_back_to_back();
        test_reset_mid_scan();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/output_argmax.md
Name: output_argmax

Overview:
- Downstream consumer of zyNet's parallel output vector of OUTPUT_SIZE signed fixed-point logits.
- Takes one vector via zyNet's demanding valid/yumi handshake and scans it sequentially, one element per cycle.
- Presents the winning class index and its value to the next stage (classification sink / host interface) over a demanding valid/yumi handshake.

Parameters:
- WORD_SIZE, 16, bit width of each logit (signed two's complement, Q(WORD_SIZE-N_SIZE).N_SIZE).
- N_SIZE, 12, fractional bits; carried for consistency only, no effect on comparison.
- OUTPUT_SIZE, 10, number of logits per vector; must be >= 2, elaboration error otherwise.
- INDEX_BITS, $clog2(OUTPUT_SIZE), width of class index output.

Ports:
- clk_i  input  1  clock, all logic on rising edge.
- reset_n_i  input  1  synchronous, active-low reset.
- valid_i  input  1  upstream vector valid (zyNet valid_o).
- data_i  input  [OUTPUT_SIZE-1:0][WORD_SIZE-1:0]  logit vector, element k = class k, signed.
- yumi_o  output  1  consumes upstream vector this cycle.
- valid_o  output  1  result valid, held until yumi_i.
- class_o  output  INDEX_BITS  index of maximum logit.
- max_o  output  WORD_SIZE  value of maximum logit, signed.
- yumi_i  input  1  downstream consumes result.

Behaviour:
- States: IDLE, SCAN, DONE.
- Reset (reset_n_i low at clk edge): state IDLE; valid_o=0, class_o=0, max_o=0; vector register and counter cleared. Reset mid-SCAN or mid-DONE discards the in-flight result; the upstream vector is not re-requested.
- yumi_o = (state==IDLE) & valid_i, combinational. It is never asserted outside IDLE or during reset.
- IDLE: on valid_i at edge T
  - latch data_i into the internal vector register;
  - running max <= element 0, running index <= 0, counter <= 1;
  - go to SCAN.
- SCAN: each cycle compare element[counter] against running max, signed.
  - Strictly greater replaces max and index; ties keep the lower index.
  - Counter increments.
  - After the compare of element OUTPUT_SIZE-1, go to DONE.
  - SCAN therefore lasts OUTPUT_SIZE-1 cycles.
- Latency: yumi_o high in cycle T; valid_o first high in cycle T+OUTPUT_SIZE (T+10 at default).
- DONE: valid_o=1. class_o and max_o are registered and stable while valid_o is high.
  - yumi_i high: valid_o drops next cycle, state returns to IDLE.
  - A new vector is accepted no earlier than the cycle after the return to IDLE; there is no bypass.
- yumi_i while valid_o=0 is ignored.
- valid_i held high by upstream during SCAN/DONE: no effect, yumi_o stays 0.
- Compare is full-width signed: 16'h8000 is the minimum, 16'h7FFF the maximum.
- class_o/max_o keep the previous result after yumi_i until the next DONE. Only valid_o qualifies them.

Optional Feature:
- Macro ARGMAX_MARGIN_EN.
- Defined:
  - adds output port margin_o [WORD_SIZE-1:0], unsigned;
  - SCAN also tracks the runner-up;
  - margin_o = max - runner_up, computed at WORD_SIZE+1 bits and saturated to 2^WORD_SIZE-1;
  - valid with valid_o; reset value 0;
  - a tie for max gives margin_o=0.
- Undefined: port absent, no runner-up logic; all other behaviour identical.

Test Plan:
- Reset/idle: hold reset_n_i low 2 cycles with valid_i=1 -> yumi_o=0, valid_o=0, class_o=0, max_o=0.
- Basic argmax:
  - stimulus: vector all 16'h0000 except element 7=16'h1800 (1.5), element 3=16'h1000; yumi_o pulse at T;
  - response: valid_o at T+10, class_o=7, max_o=16'h1800; with ARGMAX_MARGIN_EN, margin_o=16'h0800.
- Signed/tie:
  - stimulus: all elements 16'hF000 (-1.0), elements 2 and 5=16'hFF00;
  - response: class_o=2, max_o=16'hFF00, margin_o=0.
- Extremes:
  - stimulus: element 0=16'h8000, element 9=16'h7FFF, others 16'h8000;
  - response: class_o=9; margin_o=16'hFFFF (saturated edge).
- Backpressure/back-to-back:
  - stimulus: hold yumi_i=0 for 20 cycles after valid_o with valid_i held high and a second vector waiting;
  - response: valid_o and outputs stable, yumi_o=0 throughout; after the yumi_i pulse, second yumi_o occurs exactly 1 cycle after the return to IDLE.
- Reset mid-scan:
  - stimulus: assert reset_n_i low at T+4;
  - response: valid_o never rises for that vector; next vector is processed normally with correct class_o.
